// File: rtl/tournament_select_if.sv
// Fitness write-back, tournament request and result bundle for tournament_select.
// master side = fitness_eval / GA controller, slave side = the selection stage.
interface tournament_select_if #(
  parameter int SELF_FIT_LENGTH = 10,
  parameter int IDX_WIDTH       = 6
);
  logic                       gen_clear_i;
  logic                       fit_valid_i;
  logic [IDX_WIDTH-1:0]       fit_idx_i;
  logic [SELF_FIT_LENGTH-1:0] fit_energy_i;
  logic                       fit_done_i;
  logic                       sel_req_i;
  logic [IDX_WIDTH-1:0]       cand_a_i;
  logic [IDX_WIDTH-1:0]       cand_b_i;
  logic                       ready_ff_o;
  logic                       sel_valid_ff_o;
  logic [IDX_WIDTH-1:0]       sel_idx_ff_o;
  logic [SELF_FIT_LENGTH-1:0] sel_energy_ff_o;
  logic [IDX_WIDTH-1:0]       best_idx_ff_o;
  logic [SELF_FIT_LENGTH-1:0] best_energy_ff_o;

  modport master (
    output gen_clear_i, fit_valid_i, fit_idx_i, fit_energy_i, fit_done_i,
           sel_req_i, cand_a_i, cand_b_i,
    input  ready_ff_o, sel_valid_ff_o, sel_idx_ff_o, sel_energy_ff_o,
           best_idx_ff_o, best_energy_ff_o
  );

  modport slave (
    input  gen_clear_i, fit_valid_i, fit_idx_i, fit_energy_i, fit_done_i,
           sel_req_i, cand_a_i, cand_b_i,
    output ready_ff_o, sel_valid_ff_o, sel_idx_ff_o, sel_energy_ff_o,
           best_idx_ff_o, best_energy_ff_o
  );
endinterface

// File: rtl/tournament_select.sv
// Stores per-individual energies, tracks the lowest, then serves binary tournaments (lower wins).
// Latency 1 for write->best and request->result; no backpressure, one request per cycle in SELECT.
module tournament_select #(
  parameter int SELF_FIT_LENGTH = 10,
  parameter int POP_SIZE        = 50,
  parameter int IDX_WIDTH       = 6
) (
  input logic                clk_i,
  input logic                rst_n,
  tournament_select_if.slave bus
);

  typedef enum logic {S_LOAD = 1'b0, S_SELECT = 1'b1} state_e;

  localparam logic [SELF_FIT_LENGTH-1:0] E_MAX   = '1;
  localparam logic [IDX_WIDTH:0]         POP_LIM = (IDX_WIDTH+1)'(POP_SIZE);

  state_e                     state_q, state_d;
  logic [SELF_FIT_LENGTH-1:0] mem_q [POP_SIZE];
  logic [SELF_FIT_LENGTH-1:0] mem_d [POP_SIZE];
  logic [POP_SIZE-1:0]        loaded_q, loaded_d;
  logic                       ready_q, ready_d;
  logic                       sel_valid_q, sel_valid_d;
  logic [IDX_WIDTH-1:0]       sel_idx_q, sel_idx_d;
  logic [SELF_FIT_LENGTH-1:0] sel_energy_q, sel_energy_d;
  logic [IDX_WIDTH-1:0]       best_idx_q, best_idx_d;
  logic [SELF_FIT_LENGTH-1:0] best_energy_q, best_energy_d;

  logic                       wr_en;
  logic                       a_ok, b_ok, a_wins;
  logic [SELF_FIT_LENGTH-1:0] a_energy, b_energy;

  always_comb begin
    wr_en = (state_q == S_LOAD) && bus.fit_valid_i && ({1'b0, bus.fit_idx_i} < POP_LIM);

    // Invalid candidates read as all-ones and can only win when the other side is invalid too.
    a_ok     = ({1'b0, bus.cand_a_i} < POP_LIM) && loaded_q[bus.cand_a_i];
    b_ok     = ({1'b0, bus.cand_b_i} < POP_LIM) && loaded_q[bus.cand_b_i];
    a_energy = a_ok ? mem_q[bus.cand_a_i] : E_MAX;
    b_energy = b_ok ? mem_q[bus.cand_b_i] : E_MAX;
    a_wins   = !b_ok || (a_ok && (a_energy <= b_energy));

    state_d       = state_q;
    mem_d         = mem_q;
    loaded_d      = loaded_q;
    sel_valid_d   = 1'b0;
    sel_idx_d     = sel_idx_q;
    sel_energy_d  = sel_energy_q;
    best_idx_d    = best_idx_q;
    best_energy_d = best_energy_q;

    if (bus.gen_clear_i) begin
      state_d       = S_LOAD;
      loaded_d      = '0;
      best_idx_d    = '0;
      best_energy_d = E_MAX;
    end else if (state_q == S_LOAD) begin
      if (wr_en) begin
        mem_d[bus.fit_idx_i]    = bus.fit_energy_i;
        loaded_d[bus.fit_idx_i] = 1'b1;
        if (bus.fit_energy_i < best_energy_q) begin
          best_idx_d    = bus.fit_idx_i;
          best_energy_d = bus.fit_energy_i;
        end
      end
      // The write on this edge counts towards completion.
      if ((&loaded_d) || bus.fit_done_i) begin
        state_d = S_SELECT;
      end
    end else if (bus.sel_req_i) begin
      sel_valid_d  = 1'b1;
      sel_idx_d    = a_wins ? bus.cand_a_i : bus.cand_b_i;
      sel_energy_d = a_wins ? a_energy : b_energy;
    end

    ready_d = (state_d == S_SELECT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q       <= S_LOAD;
      loaded_q      <= '0;
      ready_q       <= 1'b0;
      sel_valid_q   <= 1'b0;
      sel_idx_q     <= '0;
      sel_energy_q  <= '0;
      best_idx_q    <= '0;
      best_energy_q <= E_MAX;
    end else begin
      state_q       <= state_d;
      loaded_q      <= loaded_d;
      ready_q       <= ready_d;
      sel_valid_q   <= sel_valid_d;
      sel_idx_q     <= sel_idx_d;
      sel_energy_q  <= sel_energy_d;
      best_idx_q    <= best_idx_d;
      best_energy_q <= best_energy_d;
    end
  end

  // Energy storage is qualified by the loaded bits, so it needs no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign bus.ready_ff_o       = ready_q;
  assign bus.sel_valid_ff_o   = sel_valid_q;
  assign bus.sel_idx_ff_o     = sel_idx_q;
  assign bus.sel_energy_ff_o  = sel_energy_q;
  assign bus.best_idx_ff_o    = best_idx_q;
  assign bus.best_energy_ff_o = best_energy_q;

endmodule
